// File: rtl/pipo_access_arbiter.sv
// Shared WIDTH-bit holding register written by two requesters.
// Round-robin arbitration, then grant -> load -> acknowledge, one cycle each.
module pipo_access_arbiter #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             req1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_sel;     // requester owning the current transaction
    logic             r_ptr;     // requester favoured when both ask at once
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_ack0;
    logic             r_ack1;

    logic             w_any;
    logic             w_win;

    assign w_any = req0 | req1;

    always_comb begin
        // NOTE: default assignment first, so every path drives w_win and no latch is inferred.
        w_win = req1;
        if (req0 && req1) begin
            w_win = r_ptr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
            r_ptr   <= 1'b0;
            r_q     <= RESET_VAL;
            r_cnt   <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    if (w_any) begin
                        r_sel   <= w_win;
                        r_gnt0  <= ~w_win;
                        r_gnt1  <= w_win;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    // wdata is taken from the granted port even if its req has dropped.
                    r_q     <= r_sel ? wdata1 : wdata0;
                    r_cnt   <= r_cnt + CNT_ONE;
                    r_ptr   <= ~r_sel;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_ack0  <= ~r_sel;
                    r_ack1  <= r_sel;
                    r_state <= ACK;
                end
                ACK: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign q        = r_q;
    assign wr_count = r_cnt;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_pipo_access_arbiter.sv
// Bench for pipo_access_arbiter: directed scenarios plus random traffic against a
// transaction-timing model (grant at E, load at E+1, next sample at E+3).
module tb_pipo_access_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [3:0] wdata0, wdata1;

    logic       gnt0_a, gnt1_a, ack0_a, ack1_a, busy_a;
    logic [3:0] q_a;
    logic [7:0] cnt_a;
    logic       gnt0_b, gnt1_b, ack0_b, ack1_b, busy_b;
    logic [3:0] q_b;
    logic [1:0] cnt_b;

    int vectors    = 0;
    int miscompares = 0;

    // transaction-level model state
    int         edge_n  = 0;
    bit         m_have  = 0;
    int         m_start = 0;
    bit         m_who   = 0;
    bit         m_ptr   = 0;
    int         m_cnt   = 0;
    logic [3:0] m_q     = 4'h0;

    always #5 clk = ~clk;

    pipo_access_arbiter #(.WIDTH(4), .RESET_VAL(4'h0), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset),
        .req0(req0), .wdata0(wdata0), .req1(req1), .wdata1(wdata1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .ack0(ack0_a), .ack1(ack1_a),
        .q(q_a), .busy(busy_a), .wr_count(cnt_a)
    );

    pipo_access_arbiter #(.WIDTH(4), .RESET_VAL(4'h0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset),
        .req0(req0), .wdata0(wdata0), .req1(req1), .wdata1(wdata1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .ack0(ack0_b), .ack1(ack1_b),
        .q(q_b), .busy(busy_b), .wr_count(cnt_b)
    );

    // One clock edge: update the model from the inputs seen at the edge, then compare 1ns later.
    task automatic tick();
        logic [19:0] exp_v, act_v;
        bit e_g0, e_g1, e_a0, e_a1, e_busy, idle;
        @(posedge clk);
        edge_n++;
        if (reset) begin
            m_have = 0;
            m_ptr  = 0;
            m_cnt  = 0;
            m_q    = 4'h0;
        end else begin
            if (m_have && edge_n == m_start + 1) begin
                m_q   = m_who ? wdata1 : wdata0;
                m_cnt = m_cnt + 1;
                m_ptr = !m_who;
            end
            idle = !m_have || (edge_n >= m_start + 3);
            if (idle && (req0 || req1)) begin
                m_who   = (req0 && req1) ? m_ptr : req1;
                m_start = edge_n;
                m_have  = 1;
            end
        end
        e_g0   = m_have && edge_n == m_start     && !m_who;
        e_g1   = m_have && edge_n == m_start     &&  m_who;
        e_a0   = m_have && edge_n == m_start + 1 && !m_who;
        e_a1   = m_have && edge_n == m_start + 1 &&  m_who;
        e_busy = m_have && edge_n <= m_start + 1;
        #1;
        exp_v = {e_g0, e_g1, e_a0, e_a1, e_busy, m_q, m_cnt[7:0], m_cnt[1:0], e_busy};
        act_v = {gnt0_a, gnt1_a, ack0_a, ack1_a, busy_a, q_a, cnt_a, cnt_b, busy_b};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL model edge=%0d {g0,g1,a0,a1,busy,q,cnt8,cnt2,busy_b} got=%b exp=%b",
                     edge_n, act_v, exp_v);
        end
    endtask

    task automatic do_reset(int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req0 = 1'b1; wdata0 = 4'b1010; req1 = 1'b0; wdata1 = 4'h0;
        do_reset(2);
        vectors++;
        if ({q_a, gnt0_a, gnt1_a, ack0_a, ack1_a, busy_a, cnt_a} !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_state got q=%b g=%b%b a=%b%b busy=%b cnt=%0d exp all zero",
                     q_a, gnt0_a, gnt1_a, ack0_a, ack1_a, busy_a, cnt_a);
        end
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        do_reset(1);
        req0 = 1'b1; wdata0 = 4'b0101;
        tick();
        req0 = 1'b0;
        vectors++;
        if ({gnt0_a, gnt1_a} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_gnt got=%b%b exp=10", gnt0_a, gnt1_a);
        end
        tick();
        vectors++;
        if ({q_a, ack0_a, ack1_a, gnt0_a, cnt_a} !== {4'b0101, 3'b100, 8'd1}) begin
            miscompares++;
            $display("FAIL single_load got q=%b a0=%b a1=%b g0=%b cnt=%0d exp q=0101 a0=1 a1=0 g0=0 cnt=1",
                     q_a, ack0_a, ack1_a, gnt0_a, cnt_a);
        end
        tick();
        vectors++;
        if ({ack0_a, busy_a, q_a} !== {2'b00, 4'b0101}) begin
            miscompares++;
            $display("FAIL single_ackdrop got a0=%b busy=%b q=%b exp 0 0 0101", ack0_a, busy_a, q_a);
        end
    endtask

    task automatic test_contention();
        int who_q[$];
        int at_q[$];
        logic [3:0] data_q[$];
        do_reset(1);
        req0 = 1'b1; req1 = 1'b1; wdata0 = 4'b0011; wdata1 = 4'b1100;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ack0_a || ack1_a) begin
                who_q.push_back(ack1_a ? 1 : 0);
                at_q.push_back(i);
                data_q.push_back(q_a);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        vectors++;
        if (who_q.size() != 4 || cnt_a !== 8'd4) begin
            miscompares++;
            $display("FAIL contention_count got acks=%0d cnt=%0d exp 4 4", who_q.size(), cnt_a);
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (who_q[k] != (k % 2) || data_q[k] !== ((k % 2) ? 4'b1100 : 4'b0011)
                    || at_q[k] != 2 + 3 * k) begin
                    miscompares++;
                    $display("FAIL contention_txn%0d got who=%0d q=%b at=%0d exp who=%0d at=%0d",
                             k, who_q[k], data_q[k], at_q[k], k % 2, 2 + 3 * k);
                end
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_early_deassert();
        req1 = 1'b1; wdata1 = 4'b1001;
        tick();
        vectors++;
        if (gnt1_a !== 1'b1) begin
            miscompares++;
            $display("FAIL early_gnt got gnt1=%b exp 1", gnt1_a);
        end
        req1 = 1'b0;
        tick();
        vectors++;
        if ({q_a, ack1_a} !== {4'b1001, 1'b1}) begin
            miscompares++;
            $display("FAIL early_load got q=%b ack1=%b exp 1001 1", q_a, ack1_a);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_load();
        // write by r0 first so the pointer favours r1 before the reset
        req0 = 1'b1; wdata0 = 4'b0110;
        tick();
        req0 = 1'b0;
        repeat (2) tick();
        req0 = 1'b1; wdata0 = 4'b1111;
        tick();
        req0 = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({q_a, ack0_a, ack1_a, busy_a, cnt_a} !== 15'h0) begin
            miscompares++;
            $display("FAIL midload_reset got q=%b a0=%b a1=%b busy=%b cnt=%0d exp all zero",
                     q_a, ack0_a, ack1_a, busy_a, cnt_a);
        end
        req0 = 1'b1; req1 = 1'b1;
        tick();
        req0 = 1'b0; req1 = 1'b0;
        vectors++;
        if ({gnt0_a, gnt1_a} !== 2'b10) begin
            miscompares++;
            $display("FAIL midload_ptr got g0g1=%b%b exp 10", gnt0_a, gnt1_a);
        end
        repeat (2) tick();
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            req0 = (k % 2 == 0); req1 = (k % 2 == 1);
            wdata0 = 4'($urandom); wdata1 = 4'($urandom);
            tick();
            req0 = 1'b0; req1 = 1'b0;
            tick();
            vectors++;
            if (cnt_b !== exp_cnt[k]) begin
                miscompares++;
                $display("FAIL wrap_%0d got cnt2=%0d exp %0d", k, cnt_b, exp_cnt[k]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req0   = ($urandom_range(0, 99) < 55);
            req1   = ($urandom_range(0, 99) < 55);
            wdata0 = 4'($urandom);
            wdata1 = 4'($urandom);
            reset  = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; wdata0 = 4'h0; wdata1 = 4'h0;
        test_reset();
        test_single_write();
        test_contention();
        test_early_deassert();
        test_reset_mid_load();
        test_counter_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
